dac_update_scheduler: RTL
=========================

# dac_update_scheduler

Sample-rate scheduler and source arbiter that sits in front of the dual-channel SPI DAC controller. It generates a programmable sample tick and, on each tick, selects one channel-A/B word pair from one of two requesters: the host override, or the waveform generator. It then hands the pair to the SPI engine with a start/busy handshake. It also flags underruns (no data at a tick) and overruns (a tick arrives while a transfer is in flight).

## Interface
Parameters:
- DATA_W, 12, DAC word width per channel
- DIV_W, 16, width of the sample-period divider
- UCNT_W, 16, width of the saturating underrun counter

Ports:
- clk100  in  1  100 MHz system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  run scheduler; low = stop after the current transfer
- rate_div  in  DIV_W  sample period minus 1, in clk100 cycles
- gen_a, gen_b  in  DATA_W  generator channel A/B words
- gen_valid  in  1  generator pair available
- gen_ready  out  1  generator pair consumed this cycle
- host_a, host_b  in  DATA_W  host override words
- host_valid  in  1  host pair pending
- host_ready  out  1  host pair consumed this cycle
- dac_r1, dac_r2  out  DATA_W  words to SPI engine, channel A/B
- dac_start  out  1  one-cycle transfer request to SPI engine
- dac_busy  in  1  SPI engine transfer in progress
- clr_flags  in  1  synchronous clear of overrun and underrun_cnt
- overrun  out  1  sticky: a tick arrived while not in WAIT_TICK
- underrun_cnt  out  UCNT_W  saturating count of ticks with no source data
- last_src_host  out  1  1 if the most recent latched pair came from host

## Operation
- Reset values: dac_r1 = dac_r2 = 12'h800 (midscale), dac_start = 0, gen_ready = host_ready = 0, overrun = 0, underrun_cnt = 0, last_src_host = 0, state IDLE, tick counter = 0.
- Tick counter:
  - While enable = 0, the counter holds at rate_div.
  - While enable = 1, it decrements each cycle. At 0 it asserts tick for one cycle and reloads rate_div.
  - Period is rate_div+1 cycles. A rate_div change takes effect at the next reload.
- States: IDLE, WAIT_TICK, START, WAIT_ACK, WAIT_DONE.
  - IDLE: go to WAIT_TICK when enable = 1.
  - WAIT_TICK: on tick, arbitrate and latch (below), then go to START. If enable = 0, go to IDLE.
  - START: dac_start = 1 for exactly this cycle, then WAIT_ACK.
  - WAIT_ACK: stay until dac_busy = 1, then WAIT_DONE.
  - WAIT_DONE: stay until dac_busy = 0. Then go to WAIT_TICK if enable = 1, else IDLE.
- Arbitration, evaluated in the tick cycle of WAIT_TICK only; fixed priority, host over generator:
  - If host_valid = 1: host_ready = 1 (combinational, this cycle), latch host_a/host_b, last_src_host <= 1.
  - Else if gen_valid = 1: gen_ready = 1, latch gen_a/gen_b, last_src_host <= 0.
  - Else: hold the previous dac_r1/dac_r2 and increment underrun_cnt (saturates at all-ones). A refresh transfer is still issued.
- gen_ready and host_ready are never both 1, and are never asserted outside the tick cycle.
- dac_r1/dac_r2 change only in the latch cycle and are stable from START through WAIT_DONE.
- Overrun: a tick in any state other than WAIT_TICK (START, WAIT_ACK, WAIT_DONE) sets overrun and is dropped; no latch and no handshake.
- clr_flags clears overrun and underrun_cnt. If a set or increment occurs in the same cycle, the set or increment wins.
- Dropping enable mid-transfer completes the current handshake, with no new ticks. The tick counter reloads immediately.
- Reset asserted mid-transfer returns all outputs to reset values asynchronously. The SPI engine's in-flight transfer is not aborted by this block.

## Timing
- Tick cycle T (WAIT_TICK): ready pulse and latch at T. dac_r1/dac_r2 are valid from T+1, and dac_start is high at T+1.
- Minimum tick-to-next-accept = 3 cycles + dac_busy high duration + 1. Any shorter rate_div produces overrun.
- First tick after enable rises: rate_div+1 cycles after the counter starts decrementing.
- If dac_busy never rises, the block waits in WAIT_ACK indefinitely; ticks then count as overruns.

## Test plan
- rate_div = 99, gen_valid held high, busy model 20 cycles -> dac_start every 100 cycles, gen_ready one pulse per tick, overrun = 0, dac_r1/dac_r2 equal the gen words.
- host_valid and gen_valid both high at a tick (host_a = 0x123, gen_a = 0x456) -> host_ready = 1, gen_ready = 0, dac_r1 = 0x123, last_src_host = 1.
- No source valid for 3 ticks after reset -> dac_r1 = dac_r2 = 0x800, underrun_cnt = 3, 3 dac_start pulses issued.
- rate_div = 9, dac_busy held high for 50 cycles -> overrun = 1, exactly one dac_start; clr_flags then clears it.
- enable dropped during WAIT_DONE -> busy completes, FSM reaches IDLE, no further dac_start or ready pulses.
- rst_n pulsed low in WAIT_ACK -> outputs return to reset values immediately; after release, the first dac_start occurs rate_div+2 cycles after enable is seen.

Source files
------------

// File: rtl/dac_update_scheduler.sv
// Sample-rate tick generator and host/generator arbiter feeding the
// dual-channel SPI DAC engine through a start/busy handshake.
`timescale 1ns/1ps
module dac_update_scheduler #(
  parameter int DATA_W = 12,
  parameter int DIV_W  = 16,
  parameter int UCNT_W = 16
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [DATA_W-1:0] gen_a,
  input  logic [DATA_W-1:0] gen_b,
  input  logic              gen_valid,
  output logic              gen_ready,
  input  logic [DATA_W-1:0] host_a,
  input  logic [DATA_W-1:0] host_b,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [DATA_W-1:0] dac_r1,
  output logic [DATA_W-1:0] dac_r2,
  output logic              dac_start,
  input  logic              dac_busy,
  input  logic              clr_flags,
  output logic              overrun,
  output logic [UCNT_W-1:0] underrun_cnt,
  output logic              last_src_host
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    START,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  localparam logic [DATA_W-1:0] MID =
    {1'b1, {(DATA_W-1){1'b0}}};

  state_e            state_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  cnt_d;
  logic [DATA_W-1:0] r1_q;
  logic [DATA_W-1:0] r2_q;
  logic              start_q;
  logic              ovr_q;
  logic [UCNT_W-1:0] ucnt_q;
  logic              src_q;

  logic cnt_hold;
  logic tick;
  logic accept;
  logic drop;
  logic starve;
  logic ucnt_max;

  // Counter parks at rate_div in IDLE too, so the first
  // period after enabling is always a full one.
  assign cnt_hold = !enable || (state_q == IDLE);
  assign tick     = !cnt_hold && (cnt_q == '0);
  assign accept   = tick && (state_q == WAIT_TICK);
  assign drop     = tick && (state_q != WAIT_TICK);

  assign host_ready = accept && host_valid;
  assign gen_ready  = accept && !host_valid && gen_valid;
  assign starve     = accept && !host_valid && !gen_valid;
  assign ucnt_max   = &ucnt_q;

  always_comb begin
    cnt_d = cnt_q - DIV_W'(1);
    if (cnt_hold || tick) begin
      cnt_d = rate_div;
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r1_q    <= MID;
      r2_q    <= MID;
      start_q <= 1'b0;
      ovr_q   <= 1'b0;
      ucnt_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (enable) state_q <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (tick) begin
            state_q <= START;
            start_q <= 1'b1;
          end
        end
        START: begin
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (dac_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!dac_busy) begin
            state_q <= enable ? WAIT_TICK : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (host_ready) begin
        r1_q  <= host_a;
        r2_q  <= host_b;
        src_q <= 1'b1;
      end else if (gen_ready) begin
        r1_q  <= gen_a;
        r2_q  <= gen_b;
        src_q <= 1'b0;
      end

      // A same-cycle event beats the clear.
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (clr_flags) begin
        ovr_q <= 1'b0;
      end

      if (starve) begin
        if (!ucnt_max) ucnt_q <= ucnt_q + UCNT_W'(1);
      end else if (clr_flags) begin
        ucnt_q <= '0;
      end
    end
  end

  assign dac_r1        = r1_q;
  assign dac_r2        = r2_q;
  assign dac_start     = start_q;
  assign overrun       = ovr_q;
  assign underrun_cnt  = ucnt_q;
  assign last_src_host = src_q;

endmodule
